// File: rtl/crc_pkg.sv
// crc_pkg: shared widths, FSM states and the per-lane table address helper for the slice CRC engine
package crc_pkg;
  localparam int CRC_W = 32;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  function automatic logic [CRC_W-1:0] lane_addr(input logic [BYTE_W-1:0] b, input logic [CRC_W-1:0] crc, input int k);
    logic [BYTE_W-1:0] c;
    c = (k < 4) ? BYTE_W'(crc >> (BYTE_W * k)) : '0;
    return {{(CRC_W-BYTE_W){1'b0}}, b ^ c};
  endfunction
endpackage

// File: rtl/crc_skid_reg.sv
// crc_skid_reg: one-entry valid/ready input buffer with flush, refilled in the same cycle it drains
module crc_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         pop,
  input  logic         flush
);
  // a flushed cycle still accepts the presented beat so it can be thrown away
  assign in_ready = rstn & (!out_valid | pop | flush);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/crc_slice_engine.sv
// crc_slice_engine: slice-by-NSLICE CRC-32 accumulator driving an external table bank over a valid/ready stream
module crc_slice_engine
  import crc_pkg::*;
#(
  parameter int          NSLICE     = 4,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BYTE_W*NSLICE-1:0] s_data,
  input  logic                     s_last,
  input  logic                     s_abort,
  output logic [CRC_W*NSLICE-1:0]  tab_addr,
  input  logic [CRC_W*NSLICE-1:0]  tab_rdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CRC_W-1:0]         m_crc,
  output logic [15:0]              frame_cnt
);
  localparam int DW = BYTE_W * NSLICE;
  state_t state, state_nx;
  logic [CRC_W-1:0] crc, crc_next;
  logic [DW-1:0] data;
  logic full, last, consume, flush;
  // a pending result is never dropped, so abort is ignored while it is held
  assign flush = s_abort && state != OUT;
  assign consume = full && state != OUT && !flush;
  assign m_valid = state == OUT;
  crc_skid_reg #(.W(DW + 1)) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .in_data  ({s_last, s_data}),
    .out_valid(full),
    .out_data ({last, data}),
    .pop      (consume),
    .flush    (flush)
  );
  genvar k;
  generate
    for (k = 0; k < NSLICE; k++) begin : g_lane
      assign tab_addr[CRC_W*k +: CRC_W] = lane_addr(data[BYTE_W*k +: BYTE_W], crc, k);
    end
  endgenerate
  always_comb begin
    crc_next = '0;
    for (int i = 0; i < NSLICE; i++) crc_next = crc_next ^ tab_rdata[CRC_W*i +: CRC_W];
  end
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (consume) state_nx = last ? OUT : ACC;
    else if (state == OUT && m_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      crc       <= CRC_INIT;
      m_crc     <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (flush || (consume && last)) crc <= CRC_INIT;
      else if (consume) crc <= crc_next;
      if (consume && last) m_crc <= crc_next ^ CRC_XOROUT;
      if (state == OUT && m_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_crc_slice_engine.sv
// tb_crc_slice_engine: table vectors, directed corner sequences and random frames against a bitwise CRC-32 model
module tb_crc_slice_engine;
  localparam int NS = 4;
  typedef logic [7:0] bq_t[$];
  typedef struct {int nb; logic [31:0] d0; logic [31:0] d1; logic [31:0] exp;} vec_t;
  logic clk = 0, rstn = 0, s_valid = 0, s_last = 0, s_abort = 0, m_ready = 0;
  logic s_ready, m_valid;
  logic [8*NS-1:0] s_data = '0;
  logic [32*NS-1:0] tab_addr, tab_rdata;
  logic [31:0] m_crc;
  logic [15:0] frame_cnt;
  int nchk = 0, npass = 0, cyc = 0;
  bit acc = 0, rand_ready = 0;
  logic [7:0] cur[$];
  logic [31:0] exp_q[$];
  int hs_cyc[$];
  vec_t vt[5];

  crc_slice_engine #(.NSLICE(NS)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_abort(s_abort), .tab_addr(tab_addr), .tab_rdata(tab_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] t0(input logic [7:0] b);
    logic [31:0] c = {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  // external table bank: entry = CRC state of byte b followed by s zero bytes
  function automatic logic [31:0] tab_val(input int s, input logic [7:0] b);
    logic [31:0] c = t0(b);
    for (int i = 0; i < s; i++) c = (c >> 8) ^ t0(c[7:0]);
    return c;
  endfunction

  function automatic logic [31:0] ref_crc(input bq_t q);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction

  always_comb begin
    tab_rdata = '0;
    for (int k = 0; k < NS; k++) tab_rdata[32*k +: 32] = tab_val(NS - 1 - k, tab_addr[32*k +: 8]);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    logic [31:0] e;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    acc = s_valid && s_ready;
    if (m_valid && m_ready) begin
      hs_cyc.push_back(cyc);
      check("result_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_crc_model", m_crc, e);
      end
    end
    if (rstn && s_abort) cur.delete();
    else if (acc) begin
      for (int i = 0; i < NS; i++) cur.push_back(s_data[8*i +: 8]);
      if (s_last) begin
        exp_q.push_back(ref_crc(cur));
        cur.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit l, input bit ab);
    s_valid = 1; s_data = d; s_last = l; s_abort = ab; acc = 0;
    for (int i = 0; i < 100 && !acc; i++) tick();
    check("beat_accepted", 32'(acc), 1);
    s_valid = 0; s_last = 0; s_abort = 0;
  endtask

  task automatic drain();
    rand_ready = 0;
    m_ready = 1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drained", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] fc0;
    vt[0] = '{1, 32'h00000000, 32'h0, 32'h2144DF1C};
    vt[1] = '{2, 32'h34333231, 32'h38373635, 32'h9AE0DAAF};
    vt[2] = '{1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    vt[3] = '{1, 32'h64636261, 32'h0, 32'hED82CD11};
    vt[4] = '{1, 32'h34333231, 32'h0, 32'h9BE3E0A3};
    #12;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_crc", m_crc, 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    @(negedge clk) rstn = 1;
    @(posedge clk) #1;
    check("post_rst_s_ready", 32'(s_ready), 1);

    // table vectors: exact latency, result value and frame count
    for (int v = 0; v < 5; v++) begin
      m_ready = 0;
      send_beat(vt[v].d0, vt[v].nb == 1, 0);
      if (vt[v].nb == 2) send_beat(vt[v].d1, 1, 0);
      check("vec_not_yet_valid", 32'(m_valid), 0);
      tick();
      check("vec_valid_latency", 32'(m_valid), 1);
      check("vec_m_crc", m_crc, vt[v].exp);
      m_ready = 1;
      tick();
      m_ready = 0;
      check("vec_frame_cnt", 32'(frame_cnt), v + 1);
    end

    // back-pressure hold with the next frame's first beat buffered
    send_beat(32'h34333231, 0, 0);
    send_beat(32'h38373635, 1, 0);
    tick();
    send_beat(32'h00000000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("hold_m_valid", 32'(m_valid), 1);
      check("hold_m_crc", m_crc, 32'h9AE0DAAF);
      check("hold_s_ready", 32'(s_ready), 0);
      tick();
    end
    m_ready = 1;
    tick();
    send_beat(32'h00000000, 1, 0);
    drain();

    // back-to-back single-beat frames
    hs_cyc.delete();
    s_valid = 1; s_data = '0; s_last = 1; n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      tick();
      if (acc) n++;
    end
    s_valid = 0; s_last = 0;
    drain();
    check("b2b_results", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check("b2b_gap", 32'(hs_cyc[1] - hs_cyc[0] <= 2), 1);

    // abort mid-frame, abort beating a simultaneous last
    fc0 = frame_cnt;
    m_ready = 1;
    send_beat(32'h34333231, 0, 0);
    send_beat(32'h38373635, 1, 1);
    repeat (3) tick();
    check("abort_no_result", 32'(m_valid), 0);
    check("abort_cnt_same", 32'(frame_cnt), 32'(fc0));
    send_beat(32'h00000000, 1, 0);
    tick();
    check("after_abort_crc", m_crc, 32'h2144DF1C);
    drain();
    check("abort_cnt", 32'(frame_cnt), 32'(fc0 + 16'd1));

    // reset mid-frame
    send_beat(32'h34333231, 0, 0);
    tick();
    #2 rstn = 0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 0);
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_m_crc", m_crc, 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    cur.delete();
    exp_q.delete();
    @(negedge clk) rstn = 1;
    @(posedge clk) #1;
    repeat (2) tick();
    check("midrst_quiet", 32'(m_valid), 0);
    send_beat(32'h34333231, 0, 0);
    send_beat(32'h38373635, 1, 0);
    tick();
    check("midrst_crc", m_crc, 32'h9AE0DAAF);
    drain();
    check("midrst_cnt", 32'(frame_cnt), 1);

    // random frames with random gaps and random result back-pressure
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_beat($urandom, b == n - 1, 0);
      end
    end
    drain();
    check("rand_cnt", 32'(frame_cnt), 41);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
